// File: rtl/pc_redirect.sv
// Fetch PC register with MIPS delay-slot aware redirect sequencing.
// Branch targets wait in PEND until the delay slot has been fetched.
module pc_redirect #(
    parameter logic [31:0] RESET_PC = 32'hBFC0_0000
) (
    input  logic        clk,
    input  logic        resetn,
    input  logic        stall,
    input  logic [1:0]  fetch_num,
    input  logic        branch_taken,
    input  logic [31:0] branch_target,
    input  logic        ds_fetched,
    input  logic        flush_exc,
    input  logic [31:0] exc_pc,
    output logic [31:0] pc,
    output logic        fetch_limit_one,
    output logic        redirect_pending,
    output logic        pc_misaligned
);

    localparam logic [0:0] S_RUN  = 1'b0;
    localparam logic [0:0] S_PEND = 1'b1;

    logic [31:0] r_pc;
    logic [31:0] r_pend;
    logic [0:0]  r_state;

    logic [1:0]  w_fetch_eff;
    logic        w_fetch_any;
    logic [31:0] w_pc_nxt;
    logic [31:0] w_pend_nxt;
    logic [0:0]  w_state_nxt;

    // stall masks acceptance; 3 saturates to 2
    always_comb begin
        w_fetch_eff = 2'd0;
        if (!stall)
            w_fetch_eff = (fetch_num == 2'd3) ? 2'd2 : fetch_num;
    end

    assign w_fetch_any = (w_fetch_eff != 2'd0);

    always_comb begin
        w_pc_nxt    = r_pc;
        w_pend_nxt  = r_pend;
        w_state_nxt = r_state;
        if (flush_exc) begin
            w_pc_nxt    = exc_pc;
            w_state_nxt = S_RUN;
        end else if (r_state == S_RUN) begin
            if (branch_taken && ds_fetched) begin
                w_pc_nxt = branch_target;
            end else if (branch_taken) begin
                w_pend_nxt = branch_target;
                if (w_fetch_any)
                    w_pc_nxt = branch_target;
                else
                    w_state_nxt = S_PEND;
            end else begin
                w_pc_nxt = r_pc + {28'd0, w_fetch_eff, 2'b00};
            end
        end else begin
            // branch_taken here would be a branch in a delay slot: ignored
            if (w_fetch_any) begin
                w_pc_nxt    = r_pend;
                w_state_nxt = S_RUN;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!resetn) begin
            r_pc    <= RESET_PC;
            r_pend  <= 32'd0;
            r_state <= S_RUN;
        end else begin
            r_pc    <= w_pc_nxt;
            r_pend  <= w_pend_nxt;
            r_state <= w_state_nxt;
        end
    end

    assign pc               = r_pc;
    assign fetch_limit_one  = (r_state == S_PEND);
    assign redirect_pending = (r_state == S_PEND);
    assign pc_misaligned    = (r_pc[1:0] != 2'b00);

endmodule

// File: doc/pc_redirect.md
# pc_redirect

Fetch-side PC register and redirect sequencer for the dual-issue MIPS core. It consumes the branch decision (`branch_taken`, `branch_target`) resolved in EX and the exception redirect from the commit stage, and produces the fetch PC. It enforces MIPS delay-slot semantics: a taken branch redirects fetch only after its delay slot has been fetched. If the delay slot has not been fetched yet, the target is held pending until it has.

## Interface
Parameters:
- `RESET_PC`, 32'hBFC0_0000, PC value loaded on reset.

Ports:
- `clk`  in  1  system clock; all state updates on rising edge.
- `resetn`  in  1  synchronous, active-low reset.
- `stall`  in  1  fetch stage held; sequential advance suppressed.
- `fetch_num`  in  2  instructions accepted by fetch this cycle at `pc`: 0, 1 or 2; 3 is treated as 2.
- `branch_taken`  in  1  one-cycle pulse from EX: branch/jump taken.
- `branch_target`  in  32  redirect target, valid with `branch_taken`.
- `ds_fetched`  in  1  with `branch_taken`: delay slot already fetched.
- `flush_exc`  in  1  exception/eret redirect from commit.
- `exc_pc`  in  32  redirect address, valid with `flush_exc`.
- `pc`  out  32  current fetch PC (registered).
- `fetch_limit_one`  out  1  fetch must accept at most one instruction (delay slot only).
- `redirect_pending`  out  1  a taken-branch target is held awaiting delay-slot fetch.
- `pc_misaligned`  out  1  `pc[1:0] != 2'b00` (combinational from `pc`).

## Operation
- State: `pc` (32), `pend_target` (32), FSM `state` ∈ {RUN, PEND}.
- `fetch_limit_one` = `redirect_pending` = (state == PEND).
- Next-state priority, highest first:
  1. `flush_exc`: `pc` ← `exc_pc`; state ← RUN; `pend_target` unchanged. Any concurrent `branch_taken` or fetch acceptance is discarded.
  2. RUN, `branch_taken` & `ds_fetched`: `pc` ← `branch_target`; stay RUN. `fetch_num` this cycle is ignored for PC update. Killing younger fetched instructions is downstream's job.
  3. RUN, `branch_taken` & !`ds_fetched`: `pend_target` ← `branch_target`; state ← PEND. `pc` is the delay-slot address. If `fetch_num` ≥ 1 this same cycle, the delay slot is fetched now: `pc` ← `branch_target`, state stays RUN, and `pend_target` is not used.
  4. PEND, `fetch_num` ≥ 1: `pc` ← `pend_target`; state ← RUN. A value of 2 counts as 1; the second slot is not the delay slot and is dropped by fetch under `fetch_limit_one`.
  5. PEND, `fetch_num` == 0: hold.
  6. RUN, no redirect: if !`stall`, `pc` ← `pc` + 4·`fetch_num`; if `stall`, hold.
- `branch_taken` while in PEND is illegal (branch in a delay slot) and is ignored. PEND only resolves via rule 4 or `flush_exc`.
- Redirects (rules 1–3) take effect regardless of `stall`. `stall` gates sequential advance only, and forces the effective `fetch_num` to 0.
- PC arithmetic is modulo 2^32. 32'hFFFF_FFFC + 4 wraps to 0, with no flag.
- Misaligned targets are loaded unmodified. `pc_misaligned` flags them for fetch to raise AdEL.

## Timing
- Reset (`resetn`=0 at a rising edge): `pc`=RESET_PC, state=RUN, `pend_target`=0. So `fetch_limit_one`=0, `redirect_pending`=0, `pc_misaligned`=0. Reset overrides every other input.
- Reset deasserted mid-PEND: pending target is lost and fetch restarts at RESET_PC.
- Redirect latency: 1 cycle. An input at edge N gives the new `pc` visible after edge N.
- Delay-slot path: branch at edge N with !`ds_fetched` → `fetch_limit_one`=1 from N. Delay slot accepted at edge M ≥ N → `pc`=target after M.
- No combinational path from inputs to `pc`, `fetch_limit_one` or `redirect_pending`. `pc_misaligned` depends only on `pc`.

## Test plan
- Reset/sequential: hold `resetn`=0 for 2 cycles, then run `fetch_num`=2 for 3 cycles, then 1 for 1 cycle → `pc`: BFC00000, BFC00008, BFC00010, BFC00018, BFC0001C. Assert `stall`=1 with `fetch_num`=2 → `pc` holds.
- Delay slot already fetched: at `pc`=BFC00020, `branch_taken`=1, `ds_fetched`=1, target=BFC00100 → next `pc`=BFC00100, `redirect_pending`=0 throughout.
- Pending delay slot: at `pc`=BFC00040, `branch_taken`=1, `ds_fetched`=0, `fetch_num`=0, target=BFC00200 → PEND, `fetch_limit_one`=1, `pc` holds BFC00040 for 3 stalled cycles. Then `fetch_num`=2 → `pc`=BFC00200, flags cleared.
- Same-cycle delay-slot fetch: `branch_taken`=1, `ds_fetched`=0, `fetch_num`=1, target=BFC00300 → next `pc`=BFC00300, never enters PEND.
- Exception priority: in PEND with `pend_target`=BFC00400, `flush_exc`=1, `exc_pc`=BFC00380, `fetch_num`=1 → `pc`=BFC00380, RUN. A later `fetch_num`=1 gives `pc`=BFC00384, not BFC00400.
- Edge cases: `fetch_num`=2 at `pc`=FFFFFFFC → `pc`=00000004. Target BFC00102 → `pc_misaligned`=1. `branch_taken` during PEND → ignored, the original pending target is taken. `resetn`=0 during PEND → `pc`=BFC00000, RUN.
